mouse_bus_regs: RTL and testbench

- Read-side bus peripheral for the mouse subsystem.
- Captures each completed packet from the PS/2 mouse transceiver: status byte, X, Y and a packet count.
- Raises a processor interrupt per packet and returns register contents on BUS_DATA when the processor reads its addresses.
- It is the read-direction counterpart of the write-only display peripherals on the same shared 8-bit bus.

---
 rtl/mouse_bus_regs_pkg.sv | 22 ++
 rtl/mouse_bus_regs_bus_read_port.sv | 51 +++++
 rtl/mouse_bus_regs.sv | 120 ++++++++++++
 tb/tb_mouse_bus_regs.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mouse_bus_regs_pkg.sv
// Shared definitions for the mouse bus peripheral: bus width, register map
// offsets and the default base address on the shared 8-bit processor bus.
package mouse_bus_regs_pkg;

  localparam int unsigned BusWidth = 8;
  localparam int unsigned NumRegs  = 4;
  localparam int unsigned RegIdxW  = 2;

  localparam logic [BusWidth-1:0] MouseBaseAddrDefault = 8'hA0;

  // Byte offsets from the peripheral base address.
  typedef enum logic [RegIdxW-1:0] {
    RegStatus = 2'd0,
    RegX      = 2'd1,
    RegY      = 2'd2,
    RegCount  = 2'd3
  } reg_offset_e;

  // One byte per readable register, indexed by offset.
  typedef logic [NumRegs-1:0][BusWidth-1:0] reg_file_t;

endpackage

// File: rtl/mouse_bus_regs_bus_read_port.sv
// Reusable read-only bus port: decodes a NumRegs-byte window at BaseAddr,
// muxes the selected register into an output byte and drives the shared
// data bus one cycle after the address (latency 1).
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   bus_addr_i     bus address
//   bus_we_i       bus write enable (0 = read)
//   reg_data_i     register contents, one byte per offset
//   rd_hit_o       a read of this window is being presented this cycle
//   rd_idx_o       offset of the register being read
//   bus_data_io    shared data bus, high-Z unless returning read data
module mouse_bus_regs_bus_read_port
  import mouse_bus_regs_pkg::*;
#(
  parameter logic [BusWidth-1:0] BaseAddr = MouseBaseAddrDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [BusWidth-1:0] bus_addr_i,
  input  logic                bus_we_i,
  input  reg_file_t           reg_data_i,
  output logic                rd_hit_o,
  output reg_offset_e         rd_idx_o,
  inout  wire  [BusWidth-1:0] bus_data_io
);

  logic [BusWidth-1:0] addr_off;
  logic [BusWidth-1:0] data_q;
  logic                drive_q;

  // Unsigned subtraction: addresses below the base wrap to large offsets
  // and fall outside the window.
  assign addr_off = bus_addr_i - BaseAddr;
  assign rd_hit_o = !bus_we_i && (addr_off < BusWidth'(NumRegs));
  assign rd_idx_o = reg_offset_e'(addr_off[RegIdxW-1:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      drive_q <= 1'b0;
    end else begin
      drive_q <= rd_hit_o;
      if (rd_hit_o) begin
        data_q <= reg_data_i[rd_idx_o];
      end
    end
  end

  assign bus_data_io = drive_q ? data_q : {BusWidth{1'bz}};

endmodule

// File: rtl/mouse_bus_regs.sv
// Read-side bus peripheral for the PS/2 mouse. Captures each completed
// packet (status, X, Y), counts packets, raises an interrupt per packet and
// returns register contents to the processor over the shared bus.
// Register map (read only): +0 {status[7:1], overrun}, +1 snapshot X,
// +2 snapshot Y, +3 packet count. Reading +0 snapshots X/Y and clears overrun.
// Ports:
//   CLK, RESET            system clock, asynchronous active-high reset
//   BUS_ADDR, BUS_WE      processor bus address and write enable
//   BUS_DATA              shared bus data (driven only for read responses)
//   BUS_INTERRUPT_RAISE   interrupt request, held until acknowledged
//   BUS_INTERRUPT_ACK     single-cycle acknowledge
//   MOUSE_VALID           one-cycle packet strobe from the transceiver
//   MOUSE_STATUS/X/Y      packet fields, valid with MOUSE_VALID
module mouse_bus_regs
  import mouse_bus_regs_pkg::*;
#(
  parameter logic [BusWidth-1:0] MouseBaseAddr = MouseBaseAddrDefault
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [BusWidth-1:0] BUS_ADDR,
  inout  wire  [BusWidth-1:0] BUS_DATA,
  input  logic                BUS_WE,
  output logic                BUS_INTERRUPT_RAISE,
  input  logic                BUS_INTERRUPT_ACK,
  input  logic                MOUSE_VALID,
  input  logic [BusWidth-1:0] MOUSE_STATUS,
  input  logic [BusWidth-1:0] MOUSE_X,
  input  logic [BusWidth-1:0] MOUSE_Y
);

  // Status bit 0 is never visible (replaced by overrun), so it is not stored.
  logic [BusWidth-1:1] live_status_q;
  logic [BusWidth-1:0] live_x_q, live_y_q;
  logic [BusWidth-1:0] snap_x_q, snap_y_q;
  logic [BusWidth-1:0] count_q;
  logic                raise_q, raise_d;
  logic                overrun_q, overrun_d;

  logic        rd_hit;
  reg_offset_e rd_idx;
  logic        status_rd;
  reg_file_t   reg_data;

  assign status_rd = rd_hit && (rd_idx == RegStatus);

  always_comb begin
    reg_data            = '0;
    reg_data[RegStatus] = {live_status_q, overrun_q};
    reg_data[RegX]      = snap_x_q;
    reg_data[RegY]      = snap_y_q;
    reg_data[RegCount]  = count_q;
  end

  mouse_bus_regs_bus_read_port #(
    .BaseAddr (MouseBaseAddr)
  ) u_read_port (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .bus_addr_i  (BUS_ADDR),
    .bus_we_i    (BUS_WE),
    .reg_data_i  (reg_data),
    .rd_hit_o    (rd_hit),
    .rd_idx_o    (rd_idx),
    .bus_data_io (BUS_DATA)
  );

  // A new packet beats an acknowledge in the same cycle.
  always_comb begin
    raise_d = raise_q;
    if (MOUSE_VALID) begin
      raise_d = 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_d = 1'b0;
    end
  end

  // Overrun: a packet lands while the previous one is still unacknowledged.
  // The clear from a +0 read lands on the same edge that captures the read
  // byte, so that read still returns overrun=1. Set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (MOUSE_VALID && raise_q && !BUS_INTERRUPT_ACK) begin
      overrun_d = 1'b1;
    end else if (status_rd) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      live_status_q <= '0;
      live_x_q      <= '0;
      live_y_q      <= '0;
      snap_x_q      <= '0;
      snap_y_q      <= '0;
      count_q       <= '0;
      raise_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      raise_q   <= raise_d;
      overrun_q <= overrun_d;
      if (MOUSE_VALID) begin
        live_status_q <= MOUSE_STATUS[BusWidth-1:1];
        live_x_q      <= MOUSE_X;
        live_y_q      <= MOUSE_Y;
        count_q       <= count_q + 8'd1;
      end
      // Snapshot samples pre-update live values, so a packet arriving with
      // the +0 read is deferred to the next +0 read.
      if (status_rd) begin
        snap_x_q <= live_x_q;
        snap_y_q <= live_y_q;
      end
    end
  end

  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_mouse_bus_regs.sv
module tb_mouse_bus_regs;

  logic       CLK;
  logic       RESET;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_ACK;
  logic       MOUSE_VALID;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_X;
  logic [7:0] MOUSE_Y;
  wire        BUS_INTERRUPT_RAISE;

  // Pulled-up bus: an undriven bus reads 8'hFF, which no expected
  // register value in this bench uses.
  tri1 [7:0] bus_data;
  logic       drv_en;
  logic [7:0] drv_val;
  assign bus_data = drv_en ? drv_val : 8'hzz;

  localparam logic [7:0] Idle = 8'hFF;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mouse_bus_regs #(
    .MouseBaseAddr (8'hA0)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .BUS_ADDR            (BUS_ADDR),
    .BUS_DATA            (bus_data),
    .BUS_WE              (BUS_WE),
    .BUS_INTERRUPT_RAISE (BUS_INTERRUPT_RAISE),
    .BUS_INTERRUPT_ACK   (BUS_INTERRUPT_ACK),
    .MOUSE_VALID         (MOUSE_VALID),
    .MOUSE_STATUS        (MOUSE_STATUS),
    .MOUSE_X             (MOUSE_X),
    .MOUSE_Y             (MOUSE_Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single read: bus idle before the edge, data one cycle after the
  // address, released the cycle after the address leaves the window.
  task automatic read_reg(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    BUS_ADDR = addr;
    BUS_WE   = 1'b0;
    check({tag, "_pre"}, bus_data, Idle);
    tick();
    check(tag, bus_data, exp);
    BUS_ADDR = 8'h00;
    tick();
    check({tag, "_rel"}, bus_data, Idle);
  endtask

  task automatic write_reg(input logic [7:0] addr, input string tag);
    BUS_ADDR = addr;
    BUS_WE   = 1'b1;
    drv_en   = 1'b1;
    drv_val  = 8'hFF;
    tick();
    drv_en   = 1'b0;
    BUS_WE   = 1'b0;
    BUS_ADDR = 8'h00;
    check(tag, bus_data, Idle);
  endtask

  task automatic packet(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y);
    MOUSE_VALID  = 1'b1;
    MOUSE_STATUS = st;
    MOUSE_X      = x;
    MOUSE_Y      = y;
    tick();
    MOUSE_VALID  = 1'b0;
  endtask

  task automatic ack();
    BUS_INTERRUPT_ACK = 1'b1;
    tick();
    BUS_INTERRUPT_ACK = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    BUS_ADDR = 8'h00;
    BUS_WE = 1'b0;
    BUS_INTERRUPT_ACK = 1'b0;
    MOUSE_VALID = 1'b0;
    MOUSE_STATUS = 8'h00;
    MOUSE_X = 8'h00;
    MOUSE_Y = 8'h00;
    drv_en = 1'b0;
    drv_val = 8'h00;

    // Reset state
    tick();
    tick();
    RESET = 1'b0;
    tick();
    check("rst_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    check("rst_bus_idle", bus_data, Idle);
    read_reg(8'hA0, 8'h00, "rst_a0");
    read_reg(8'hA1, 8'h00, "rst_a1");
    read_reg(8'hA2, 8'h00, "rst_a2");
    read_reg(8'hA3, 8'h00, "rst_a3");
    read_reg(8'hA4, Idle, "oor_a4");

    // First packet: count 1
    packet(8'h08, 8'h50, 8'h3C);
    check("pkt1_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h01);
    read_reg(8'hA0, 8'h08, "pkt1_a0");
    read_reg(8'hA1, 8'h50, "pkt1_a1");
    read_reg(8'hA2, 8'h3C, "pkt1_a2");
    read_reg(8'hA3, 8'h01, "pkt1_a3");
    // Back-to-back reads stream one byte per cycle
    BUS_ADDR = 8'hA1;
    tick();
    check("stream_a1", bus_data, 8'h50);
    BUS_ADDR = 8'hA2;
    tick();
    check("stream_a2", bus_data, 8'h3C);
    BUS_ADDR = 8'h00;
    tick();
    check("stream_rel", bus_data, Idle);
    ack();
    check("pkt1_ack", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);

    // Snapshot coherence: packets 2,3 (count 3); packet 3 overruns
    packet(8'h00, 8'h10, 8'h00);
    read_reg(8'hA0, 8'h00, "snap_a0_first");
    packet(8'h00, 8'h20, 8'h00);
    read_reg(8'hA1, 8'h10, "snap_a1_old");
    read_reg(8'hA0, 8'h01, "snap_a0_ovr");
    read_reg(8'hA1, 8'h20, "snap_a1_new");
    read_reg(8'hA0, 8'h00, "snap_a0_clr");
    ack();

    // Overrun: packets 4,5 without ack (count 5)
    packet(8'h02, 8'h01, 8'h01);
    packet(8'h02, 8'h01, 8'h01);
    read_reg(8'hA0, 8'h03, "ovr_set");
    read_reg(8'hA0, 8'h02, "ovr_clr");
    // Packet 6 with ack in the same cycle (count 6): raise stays, no overrun
    MOUSE_VALID = 1'b1;
    MOUSE_STATUS = 8'h05;
    MOUSE_X = 8'h01;
    MOUSE_Y = 8'h01;
    BUS_INTERRUPT_ACK = 1'b1;
    tick();
    MOUSE_VALID = 1'b0;
    BUS_INTERRUPT_ACK = 1'b0;
    check("vack_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h01);
    read_reg(8'hA0, 8'h04, "vack_no_ovr");
    ack();
    check("ack_clr", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    ack();
    check("ack_idle", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);

    // Count wrap: 6 + 250 = 256 packets
    for (int i = 0; i < 250; i++) begin
      packet(8'h40, 8'h11, 8'h22);
    end
    read_reg(8'hA3, 8'h00, "wrap_a3");
    read_reg(8'hA0, 8'h41, "wrap_a0");

    // Writes are ignored and never drive the bus
    write_reg(8'hA0, "wr_a0");
    write_reg(8'hA1, "wr_a1");
    write_reg(8'hA2, "wr_a2");
    write_reg(8'hA3, "wr_a3");
    read_reg(8'hA0, 8'h40, "post_wr_a0");
    read_reg(8'hA1, 8'h11, "post_wr_a1");
    read_reg(8'hA2, 8'h22, "post_wr_a2");
    read_reg(8'hA3, 8'h00, "post_wr_a3");
    ack();

    // Asynchronous reset while the bus is driven
    packet(8'h08, 8'h33, 8'h44);
    BUS_ADDR = 8'hA3;
    tick();
    check("mid_drive", bus_data, 8'h01);
    #2;
    RESET = 1'b1;
    #1;
    check("mid_rst_bus", bus_data, Idle);
    check("mid_rst_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    #1;
    RESET = 1'b0;
    tick();
    check("post_rst_count", bus_data, 8'h00);
    check("post_rst_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    BUS_ADDR = 8'h00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
